// File: rtl/ddr_cmd_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : ddr_cmd_issue_if
// Brief    : Host request handshake bundle for the DDR4 command issuer.
// Revision : 1.0 - initial release
// ============================================================================
interface ddr_cmd_issue_if;
    logic        req_valid;
    logic [1:0]  req_cmd;
    logic [1:0]  req_bg;
    logic [1:0]  req_ba;
    logic [16:0] req_addr;
    logic        req_ready;

    modport master (
        output req_valid, req_cmd, req_bg, req_ba, req_addr,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_cmd, req_bg, req_ba, req_addr,
        output req_ready
    );
endinterface
`default_nettype wire

// File: rtl/ddr_cmd_issue.sv
`default_nettype none
// ============================================================================
// Module   : ddr_cmd_issue
// Brief    : DDR4 command pin driver: init passthrough, host commands, refresh.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_cmd_issue #(
    parameter int T_REFI = 6240,
    parameter int T_RP   = 11,
    parameter int T_RFC  = 208
) (
    input  wire               clock_t,
    input  wire               reset_n,
    input  wire               mrs_rdy,
    input  wire               des_rdy,
    input  wire               zqcl_rdy,
    input  wire               config_done,
    input  wire  [18:0]       mode_reg,
    ddr_cmd_issue_if.slave    host,
    output logic              cs_n,
    output logic              act_n,
    output logic              ras_n_a16,
    output logic              cas_n_a15,
    output logic              we_n_a14,
    output logic [1:0]        bg,
    output logic [1:0]        ba,
    output logic [13:0]       addr,
    output logic              ref_busy
);

    localparam logic [2:0] S_INIT     = 3'd0;
    localparam logic [2:0] S_IDLE     = 3'd1;
    localparam logic [2:0] S_PREA     = 3'd2;
    localparam logic [2:0] S_WAIT_RP  = 3'd3;
    localparam logic [2:0] S_REF      = 3'd4;
    localparam logic [2:0] S_WAIT_RFC = 3'd5;

    // {cs_n, act_n, ras_n, cas_n, we_n}
    localparam logic [4:0] c_CMD_DES  = 5'b11111;
    localparam logic [4:0] c_CMD_MRS  = 5'b01000;
    localparam logic [4:0] c_CMD_REF  = 5'b01001;
    localparam logic [4:0] c_CMD_PRE  = 5'b01010;
    localparam logic [4:0] c_CMD_RD   = 5'b01101;
    localparam logic [4:0] c_CMD_WR   = 5'b01100;
    localparam logic [4:0] c_CMD_ZQCL = 5'b01110;
    localparam logic [13:0] c_A10     = 14'h0400;

    localparam int c_WAIT_MAX = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int c_WAIT_W   = ($clog2(c_WAIT_MAX + 1) > 8) ? $clog2(c_WAIT_MAX + 1) : 8;
    localparam logic [c_WAIT_W-1:0] c_RP_LAST  = c_WAIT_W'(T_RP - 1);
    localparam logic [c_WAIT_W-1:0] c_RFC_LAST = c_WAIT_W'(T_RFC - 1);
    localparam logic [12:0] c_REFI      = 13'(T_REFI);
    localparam logic [12:0] c_REFI_LAST = 13'(T_REFI - 1);

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic [12:0]         r_ref_cnt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                w_ref_due;
    logic                w_wait_done;
    logic                w_req_ready;
    logic                w_ref_busy;
    logic [4:0]          w_cmd;
    logic [1:0]          w_bg;
    logic [1:0]          w_ba;
    logic [13:0]         w_addr;
    logic                w_unused;

    // DES requests need no action: idle pins already encode DES.
    assign w_unused = ^{des_rdy, mode_reg[18], mode_reg[14]};

    assign w_ref_due   = (r_ref_cnt == c_REFI_LAST) || (r_ref_cnt >= c_REFI);
    assign w_wait_done = ((r_state == S_WAIT_RP)  && (r_wait_cnt == c_RP_LAST)) ||
                         ((r_state == S_WAIT_RFC) && (r_wait_cnt == c_RFC_LAST));

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT:     if (config_done) w_next_state = S_IDLE;
            S_IDLE:     if (w_ref_due)   w_next_state = S_PREA;
            S_PREA:                      w_next_state = S_WAIT_RP;
            S_WAIT_RP:  if (w_wait_done) w_next_state = S_REF;
            S_REF:                       w_next_state = S_WAIT_RFC;
            S_WAIT_RFC: if (w_wait_done) w_next_state = S_IDLE;
            default:                     w_next_state = S_INIT;
        endcase
    end

    always_comb begin
        w_req_ready = 1'b0;
        w_ref_busy  = 1'b0;
        w_cmd       = c_CMD_DES;
        w_bg        = 2'b00;
        w_ba        = 2'b00;
        w_addr      = 14'h0000;
        case (r_state)
            S_INIT: begin
                if (mrs_rdy) begin
                    w_cmd  = c_CMD_MRS;
                    w_bg   = {1'b0, mode_reg[17]};
                    w_ba   = mode_reg[16:15];
                    w_addr = mode_reg[13:0];
                end else if (zqcl_rdy) begin
                    w_cmd  = c_CMD_ZQCL;
                    w_addr = c_A10;
                end
            end
            S_IDLE: begin
                // A due refresh blocks acceptance so the host keeps its request.
                w_req_ready = !w_ref_due;
                if (host.req_valid && !w_ref_due) begin
                    w_bg   = host.req_bg;
                    w_ba   = host.req_ba;
                    w_addr = host.req_addr[13:0];
                    case (host.req_cmd)
                        2'b00:   w_cmd = {2'b00, host.req_addr[16:14]};
                        2'b01:   w_cmd = c_CMD_RD;
                        2'b10:   w_cmd = c_CMD_WR;
                        default: w_cmd = c_CMD_PRE;
                    endcase
                end
            end
            S_PREA: begin
                w_ref_busy = 1'b1;
                w_cmd      = c_CMD_PRE;
                w_addr     = c_A10;
            end
            S_WAIT_RP:  w_ref_busy = 1'b1;
            S_REF: begin
                w_ref_busy = 1'b1;
                w_cmd      = c_CMD_REF;
            end
            S_WAIT_RFC: w_ref_busy = 1'b1;
            default: ;
        endcase
    end

    assign host.req_ready = w_req_ready;
    assign ref_busy       = w_ref_busy;

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            r_ref_cnt <= 13'd0;
        end else if ((r_state == S_INIT) || (r_state == S_REF)) begin
            r_ref_cnt <= 13'd0;
        end else if (r_ref_cnt < c_REFI) begin
            r_ref_cnt <= r_ref_cnt + 13'd1;
        end
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
        end else if (((r_state == S_WAIT_RP) || (r_state == S_WAIT_RFC)) && !w_wait_done) begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14} <= c_CMD_DES;
            bg   <= 2'b00;
            ba   <= 2'b00;
            addr <= 14'h0000;
        end else begin
            {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14} <= w_cmd;
            bg   <= w_bg;
            ba   <= w_ba;
            addr <= w_addr;
        end
    end

endmodule
`default_nettype wire
